// File: rtl/mem_dbus_if_pkg.sv
// Shared types and constants for the MEM-stage data-bus interface.
// Holds the transaction state encoding and the reset/zero constants
// used by mem_dbus_if and its optional dbus_watchdog.
package mem_dbus_if_pkg;

    // Reset is asserted when rst equals this level (active-low block)
    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam int          STALL_MEM_BIT = 4;

    typedef enum logic [1:0] {
        DBUS_IDLE       = 2'd0,
        DBUS_BUSY       = 2'd1,
        DBUS_WAIT_STALL = 2'd2,
        DBUS_ABORT      = 2'd3
    } dbus_state_e;

endpackage

// File: rtl/dbus_watchdog.sv
// Wait-cycle watchdog for the data bus. Only present when DBUS_TIMEOUT_EN
// is defined; counts cycles without bus_ack and flags expiry on the
// TIMEOUT_CYC-th such cycle so the master can give up on the transfer.
`ifdef DBUS_TIMEOUT_EN
module dbus_watchdog
    import mem_dbus_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count_q;

    // Expiry fires in the cycle that would be the TIMEOUT_CYC-th wait
    assign expired = count_en && (count_q == LIMIT);

    // Wait counter: cleared on entry to a waiting state, bumped per no-ack cycle
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            count_q <= 8'd0;
        end else if (clear) begin
            count_q <= 8'd0;
        end else if (count_en) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule
`endif

// File: rtl/mem_dbus_if.sv
// MEM-stage data-bus master: converts MEM's single-cycle data request into
// a req/ack bus transaction, stalls the pipeline until data returns and
// buffers load data while MEM is held. Optional bus timeout is enabled by
// defining DBUS_TIMEOUT_EN (adds the dbus_watchdog using TIMEOUT_CYC).
module mem_dbus_if
    import mem_dbus_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    dbus_state_e state_q, state_d;
    logic [31:0] rd_buf;
    logic        launch;
    logic        capture;
    logic        release_req;
    logic        wd_clear;
    logic        wd_count;
    logic        timeout_hit;
    logic        mem_held;
    logic        unused_stall;

    assign mem_held     = stall[STALL_MEM_BIT];
    assign unused_stall = ^{stall[5], stall[3:0]};

`ifdef DBUS_TIMEOUT_EN
    dbus_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .count_en(wd_count),
        .expired (timeout_hit)
    );
`else
    logic unused_wd;
    assign timeout_hit = 1'b0;
    assign unused_wd   = wd_clear ^ wd_count;
`endif

    // Next-state and MEM-facing outputs; flush beats a same-cycle ack
    always_comb begin
        state_d     = state_q;
        cpu_rdata   = ZERO_WORD;
        stallreq    = 1'b0;
        launch      = 1'b0;
        capture     = 1'b0;
        release_req = 1'b0;
        wd_clear    = 1'b0;
        wd_count    = 1'b0;
        unique case (state_q)
            DBUS_IDLE: begin
                if (cpu_ce && !flush) begin
                    launch   = 1'b1;
                    stallreq = 1'b1;
                    wd_clear = 1'b1;
                    state_d  = DBUS_BUSY;
                end
            end
            DBUS_BUSY: begin
                wd_count = !bus_ack;
                if (bus_ack) begin
                    release_req = 1'b1;
                    if (flush) begin
                        state_d = DBUS_IDLE;
                    end else begin
                        cpu_rdata = bus_rdata;
                        capture   = 1'b1;
                        state_d   = mem_held ? DBUS_WAIT_STALL : DBUS_IDLE;
                    end
                end else if (timeout_hit) begin
                    release_req = 1'b1;
                    state_d     = DBUS_IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (flush) begin
                        wd_clear = 1'b1;
                        state_d  = DBUS_ABORT;
                    end
                end
            end
            DBUS_ABORT: begin
                wd_count = !bus_ack;
                if (bus_ack || timeout_hit) begin
                    release_req = 1'b1;
                    state_d     = DBUS_IDLE;
                end else begin
                    stallreq = cpu_ce && !flush;
                end
            end
            DBUS_WAIT_STALL: begin
                cpu_rdata = rd_buf;
                if (flush || !mem_held) begin
                    state_d = DBUS_IDLE;
                end
            end
            default: begin
                state_d = DBUS_IDLE;
            end
        endcase
    end

    // State, bus master registers and load buffer; bus_* hold until the ack edge
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q   <= DBUS_IDLE;
            rd_buf    <= ZERO_WORD;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= ZERO_WORD;
            bus_sel   <= 4'b0000;
            bus_wdata <= ZERO_WORD;
            bus_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_err <= timeout_hit;
            if (launch) begin
                bus_req   <= 1'b1;
                bus_we    <= cpu_we;
                bus_addr  <= cpu_addr;
                bus_sel   <= cpu_sel;
                bus_wdata <= cpu_wdata;
            end else if (release_req) begin
                bus_req <= 1'b0;
            end
            if (capture) begin
                rd_buf <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_dbus_if.sv
// Directed self-checking bench for mem_dbus_if. Inputs change 1 time unit
// after each rising edge and outputs are sampled 1 unit later, well clear
// of the next edge. Define DBUS_TIMEOUT_EN to also exercise the timeout.
`timescale 1ns/1ps
module tb_mem_dbus_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_dbus_if #(.TIMEOUT_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .cpu_ce   (cpu_ce),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_sel  (cpu_sel),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .stallreq (stallreq),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_sel  (bus_sel),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall     = 6'b0;
        flush     = 1'b0;
        cpu_ce    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_sel   = 4'h0;
        cpu_wdata = 32'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        #12;
        checks++;
        if ({bus_req, bus_we, bus_err, stallreq} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 0000", {bus_req, bus_we, bus_err, stallreq});
        end
        checks++;
        if ({bus_addr, bus_wdata, bus_sel} !== 68'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus got %h/%h/%h want 0", bus_addr, bus_wdata, bus_sel);
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %h want 0", cpu_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load();
        step();
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_sel = 4'hF;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_launch_stallreq got %b want 1", stallreq);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({stallreq, bus_req, bus_addr, cpu_rdata} !== {2'b11, 32'h100, 32'h0}) begin
                errors++;
                $display("[TB] FAIL load_wait%0d got sr=%b req=%b addr=%h rd=%h want 1 1 100 0",
                         i, stallreq, bus_req, bus_addr, cpu_rdata);
            end
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({stallreq, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL load_ack got sr=%b rd=%h want 0 deadbeef", stallreq, cpu_rdata);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if ({bus_req, stallreq, cpu_rdata} !== {2'b00, 32'h0}) begin
            errors++;
            $display("[TB] FAIL load_idle got req=%b sr=%b rd=%h want 0 0 0", bus_req, stallreq, cpu_rdata);
        end
    endtask

    task automatic test_store();
        step();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_sel = 4'b0011; cpu_wdata = 32'h1234;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_launch_stallreq got %b want 1", stallreq);
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h5555_0000;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata, stallreq} !==
            {2'b11, 32'h200, 4'b0011, 32'h1234, 1'b0}) begin
            errors++;
            $display("[TB] FAIL store_bus got req=%b we=%b addr=%h sel=%b wd=%h sr=%b want 1 1 200 0011 1234 0",
                     bus_req, bus_we, bus_addr, bus_sel, bus_wdata, stallreq);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if ({bus_req, cpu_rdata} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL store_done got req=%b rd=%h want 0 0", bus_req, cpu_rdata);
        end
    endtask

    task automatic test_wait_stall();
        step();
        cpu_ce = 1'b1; cpu_addr = 32'h300; cpu_sel = 4'hF;
        step();
        bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5; stall = 6'b010000;
        #1;
        checks++;
        if ({stallreq, cpu_rdata} !== {1'b0, 32'hA5A5A5A5}) begin
            errors++;
            $display("[TB] FAIL ws_ack got sr=%b rd=%h want 0 a5a5a5a5", stallreq, cpu_rdata);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            bus_ack = 1'b0; bus_rdata = 32'h0;
            #1;
            checks++;
            if ({stallreq, bus_req, cpu_rdata} !== {2'b00, 32'hA5A5A5A5}) begin
                errors++;
                $display("[TB] FAIL ws_hold%0d got sr=%b req=%b rd=%h want 0 0 a5a5a5a5",
                         i, stallreq, bus_req, cpu_rdata);
            end
        end
        step();
        stall = 6'b0;
        #1;
        checks++;
        if (cpu_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL ws_release got %h want a5a5a5a5", cpu_rdata);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if ({bus_req, stallreq, cpu_rdata} !== {2'b00, 32'h0}) begin
            errors++;
            $display("[TB] FAIL ws_idle got req=%b sr=%b rd=%h want 0 0 0", bus_req, stallreq, cpu_rdata);
        end
    endtask

    task automatic test_abort();
        step();
        cpu_ce = 1'b1; cpu_addr = 32'h400; cpu_sel = 4'hF;
        step();
        flush = 1'b1;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_flush_sr got %b want 1", stallreq);
        end
        step();
        flush = 1'b0; cpu_addr = 32'h404;
        #1;
        checks++;
        if ({bus_req, stallreq, cpu_rdata, bus_addr} !== {2'b11, 32'h0, 32'h400}) begin
            errors++;
            $display("[TB] FAIL abort_hold got req=%b sr=%b rd=%h addr=%h want 1 1 0 400",
                     bus_req, stallreq, cpu_rdata, bus_addr);
        end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h77;
        #1;
        checks++;
        if ({bus_req, cpu_rdata} !== {1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL abort_ack got req=%b rd=%h want 1 0", bus_req, cpu_rdata);
        end
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        checks++;
        if ({bus_req, stallreq} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL abort_idle_launch got req=%b sr=%b want 0 1", bus_req, stallreq);
        end
        step();
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h404}) begin
            errors++;
            $display("[TB] FAIL abort_relaunch got req=%b addr=%h want 1 404", bus_req, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h11;
        #1;
        checks++;
        if (cpu_rdata !== 32'h11) begin
            errors++;
            $display("[TB] FAIL abort_second_data got %h want 11", cpu_rdata);
        end
        step();
        drive_idle();
    endtask

    task automatic test_ack_flush();
        step();
        cpu_ce = 1'b1; cpu_addr = 32'h600; cpu_sel = 4'hF;
        step();
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; flush = 1'b1; stall = 6'b010000;
        #1;
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL ackflush_rdata got %h want 0", cpu_rdata);
        end
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0; flush = 1'b0; cpu_ce = 1'b0;
        #1;
        checks++;
        if ({bus_req, cpu_rdata} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL ackflush_no_wait got req=%b rd=%h want 0 0", bus_req, cpu_rdata);
        end
        step();
        drive_idle();
    endtask

    task automatic test_reset_mid();
        step();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500; cpu_sel = 4'hF; cpu_wdata = 32'h99;
        step();
        cpu_ce = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_err, stallreq, bus_addr, bus_sel, bus_wdata} !== 72'h0) begin
            errors++;
            $display("[TB] FAIL midreset got req=%b we=%b addr=%h sel=%h wd=%h want all 0",
                     bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
        end
        #1;
        rst = 1'b1;
        step();
        bus_ack = 1'b1; bus_rdata = 32'hBAD;
        #1;
        checks++;
        if ({bus_req, stallreq, cpu_rdata} !== {2'b00, 32'h0}) begin
            errors++;
            $display("[TB] FAIL midreset_late_ack got req=%b sr=%b rd=%h want 0 0 0", bus_req, stallreq, cpu_rdata);
        end
        step();
        drive_idle();
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic test_timeout();
        step();
        cpu_ce = 1'b1; cpu_addr = 32'h700; cpu_sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({stallreq, bus_err} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL to_wait%0d got sr=%b err=%b want 1 0", i, stallreq, bus_err);
            end
        end
        step();
        cpu_ce = 1'b0;
        #1;
        checks++;
        if ({stallreq, bus_err, cpu_rdata} !== {2'b00, 32'h0}) begin
            errors++;
            $display("[TB] FAIL to_expire got sr=%b err=%b rd=%h want 0 0 0", stallreq, bus_err, cpu_rdata);
        end
        step();
        checks++;
        if ({bus_err, bus_req} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL to_pulse got err=%b req=%b want 1 0", bus_err, bus_req);
        end
        step();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_pulse_end got %b want 0", bus_err);
        end
        drive_idle();
    endtask
`endif

    // Runs every scenario in order, then prints the summary
    initial begin
        test_reset();
        test_load();
        test_store();
        test_wait_stall();
        test_abort();
        test_ack_flush();
        test_reset_mid();
`ifdef DBUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
